store_arbiter: RTL and testbench

- Shares the single data-memory write port between the two store lanes of the dual-issue pipeline.
- Accepts up to two stores per cycle in program order (lane 0 older than lane 1) into an in-order store queue.
- Drains the queue one store per cycle onto the write port (we/wa/wd/wm) of the memory block.
- Reports load/store address hazards so the load lanes can stall on a pending store to the same word.

---
 rtl/store_arbiter.sv | 137 +++++++++++++
 tb/tb_store_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/store_arbiter.sv
// store_arbiter: two-lane in-order store queue draining onto one memory write port.
// Optional store-to-load data forwarding on chk_data is enabled by defining STORE_FWD_EN.
module store_arbiter #(
    parameter int DEPTH = 4,
    parameter int MODE_W = 3,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][31:0]       req_addr,
    input  logic [1:0][31:0]       req_data,
    input  logic [1:0][MODE_W-1:0] req_mode,
    input  logic                   drain_en,
    output logic                   we,
    output logic [31:0]            wa,
    output logic [31:0]            wd,
    output logic [MODE_W-1:0]      wm,
    input  logic [1:0][31:0]       chk_addr,
    output logic [1:0]             chk_hit,
    output logic [1:0][31:0]       chk_data,
    output logic                   empty
);
    localparam logic [PTR_W:0] CNT_M1 = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W:0] CNT_M2 = (PTR_W+1)'(DEPTH - 2);

    logic [PTR_W:0]    count_q, count_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, tail1;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [31:0]       addr_q [DEPTH];
    logic [31:0]       addr_d [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [31:0]       data_d [DEPTH];
    logic [MODE_W-1:0] mode_q [DEPTH];
    logic [MODE_W-1:0] mode_d [DEPTH];
    logic              we_q, we_d;
    logic [31:0]       wa_q, wa_d, wd_q, wd_d;
    logic [MODE_W-1:0] wm_q, wm_d;
    logic              push0, push1, pop;

    // Word-granular compare; byte offset bits are masked out.
    function automatic logic word_eq(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) & 32'hFFFF_FFFC) == 32'h0;
    endfunction

    always_comb begin
        req_ready[0] = count_q <= CNT_M1;
        req_ready[1] = req_valid[0] ? (count_q <= CNT_M2) : (count_q <= CNT_M1);
        push0 = req_valid[0] & req_ready[0];
        push1 = req_valid[1] & req_ready[1];
        pop = (count_q != '0) & drain_en;
        tail1 = tail_q + PTR_W'(push0);
        count_d = count_q + (PTR_W+1)'(push0) + (PTR_W+1)'(push1) - (PTR_W+1)'(pop);
        head_d = head_q + PTR_W'(pop);
        tail_d = tail1 + PTR_W'(push1);
        valid_d = valid_q;
        addr_d = addr_q;
        data_d = data_q;
        mode_d = mode_q;
        if (pop) valid_d[head_q] = 1'b0;
        if (push0) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q] = req_addr[0];
            data_d[tail_q] = req_data[0];
            mode_d[tail_q] = req_mode[0];
        end
        if (push1) begin
            valid_d[tail1] = 1'b1;
            addr_d[tail1] = req_addr[1];
            data_d[tail1] = req_data[1];
            mode_d[tail1] = req_mode[1];
        end
        we_d = pop;
        wa_d = pop ? addr_q[head_q] : wa_q;
        wd_d = pop ? data_q[head_q] : wd_q;
        wm_d = pop ? mode_q[head_q] : wm_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            valid_q <= '0;
            we_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
            wm_q <= '0;
        end else begin
            count_q <= count_d;
            head_q <= head_d;
            tail_q <= tail_d;
            valid_q <= valid_d;
            we_q <= we_d;
            wa_q <= wa_d;
            wd_q <= wd_d;
            wm_q <= wm_d;
        end
    end

    // Payload needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        mode_q <= mode_d;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            chk_hit[i] = we_q & word_eq(wa_q, chk_addr[i]);
            for (int e = 0; e < DEPTH; e++)
                if (valid_q[e] && word_eq(addr_q[e], chk_addr[i])) chk_hit[i] = 1'b1;
        end
    end

`ifdef STORE_FWD_EN
    // Walk oldest to youngest so the youngest match overrides.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            chk_data[i] = (we_q & word_eq(wa_q, chk_addr[i])) ? wd_q : 32'h0;
            for (int k = 0; k < DEPTH; k++) begin
                if (valid_q[head_q + PTR_W'(k)] && word_eq(addr_q[head_q + PTR_W'(k)], chk_addr[i]))
                    chk_data[i] = data_q[head_q + PTR_W'(k)];
            end
        end
    end
`else
    assign chk_data = '0;
`endif

    assign we = we_q;
    assign wa = wa_q;
    assign wd = wd_q;
    assign wm = wm_q;
    assign empty = (count_q == '0) & ~we_q;
endmodule

// File: tb/tb_store_arbiter.sv
// tb_store_arbiter: directed vectors with hand-computed expectations for store_arbiter.
module tb_store_arbiter;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_data;
    logic [1:0][2:0]  req_mode;
    logic             drain_en;
    logic             we;
    logic [31:0]      wa, wd;
    logic [2:0]       wm;
    logic [1:0][31:0] chk_addr;
    logic [1:0]       chk_hit;
    logic [1:0][31:0] chk_data;
    logic             empty;
    int               n_chk = 0;
    int               n_bad = 0;

    store_arbiter #(.DEPTH(4), .MODE_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_mode(req_mode),
        .drain_en(drain_en),
        .we(we), .wa(wa), .wd(wd), .wm(wm),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .chk_data(chk_data),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] d0,
                        input logic [31:0] a1, input logic [31:0] d1);
        req_valid = v;
        req_addr[0] = a0;
        req_data[0] = d0;
        req_addr[1] = a1;
        req_data[1] = d1;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        check({tag, "_we"}, 32'(we), 32'd1);
        check({tag, "_wa"}, wa, a);
        check({tag, "_wd"}, wd, d);
    endtask

    logic [31:0] fwd_fc, fwd_10e;

    initial begin
`ifdef STORE_FWD_EN
        fwd_fc = 32'h41;
        fwd_10e = 32'h14;
`else
        fwd_fc = 32'h0;
        fwd_10e = 32'h0;
`endif
        rst_n = 1'b0;
        drain_en = 1'b0;
        req_valid = 2'b00;
        req_addr = '0;
        req_data = '0;
        req_mode = '0;
        chk_addr = '0;
        tick();
        tick();
        check("rst_we", 32'(we), 32'd0);
        check("rst_wa", wa, 32'h0);
        check("rst_wd", wd, 32'h0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ready", 32'(req_ready), 32'd3);
        rst_n = 1'b1;

        // single store, visible two edges after acceptance
        drain_en = 1'b1;
        req_mode[0] = 3'd2;
        push(2'b01, 32'h10, 32'hAAAA5555, 32'h0, 32'h0);
        tick();
        req_valid = 2'b00;
        check("single_n_we", 32'(we), 32'd0);
        check("single_n_empty", 32'(empty), 32'd0);
        tick();
        expect_write("single", 32'h10, 32'hAAAA5555);
        check("single_wm", 32'(wm), 32'd2);
        chk_addr[0] = 32'h13;
        #1;
        check("hit_outreg", 32'(chk_hit[0]), 32'd1);
        tick();
        check("single_done_we", 32'(we), 32'd0);
        check("single_done_empty", 32'(empty), 32'd1);
        check("single_hold_wa", wa, 32'h10);
        #1;
        check("nohit_idle", 32'(chk_hit[0]), 32'd0);

        // dual push, issued in lane order
        push(2'b11, 32'h20, 32'h1, 32'h24, 32'h2);
        tick();
        req_valid = 2'b00;
        tick();
        expect_write("dual0", 32'h20, 32'h1);
        tick();
        expect_write("dual1", 32'h24, 32'h2);
        tick();
        check("dual_done_we", 32'(we), 32'd0);

        // fill to DEPTH with drain held off
        drain_en = 1'b0;
        push(2'b11, 32'h100, 32'h11, 32'h104, 32'h12);
        tick();
        push(2'b11, 32'h108, 32'h13, 32'h10C, 32'h14);
        tick();
        chk_addr[0] = 32'h10E;
        chk_addr[1] = 32'h200;
        #1;
        check("full_ready", 32'(req_ready), 32'd0);
        check("full_hit0", 32'(chk_hit[0]), 32'd1);
        check("full_hit1", 32'(chk_hit[1]), 32'd0);
        check("full_fwd0", chk_data[0], fwd_10e);
        check("full_fwd1", chk_data[1], 32'h0);
        tick();
        req_valid = 2'b00;
        check("full_hold_we", 32'(we), 32'd0);
        check("full_hold_empty", 32'(empty), 32'd0);
        drain_en = 1'b1;
        tick();
        expect_write("full0", 32'h100, 32'h11);
        tick();
        expect_write("full1", 32'h104, 32'h12);
        tick();
        expect_write("full2", 32'h108, 32'h13);
        tick();
        expect_write("full3", 32'h10C, 32'h14);
        tick();
        check("full_done_we", 32'(we), 32'd0);
        check("full_done_empty", 32'(empty), 32'd1);

        // count=3: only lane 0 accepted; push+pop keeps count at 3
        drain_en = 1'b0;
        push(2'b11, 32'h30, 32'h5, 32'h34, 32'h6);
        tick();
        push(2'b01, 32'hFC, 32'h41, 32'h0, 32'h0);
        tick();
        req_valid = 2'b00;
        chk_addr[0] = 32'hFE;
        chk_addr[1] = 32'h34;
        #1;
        check("c3_hit0", 32'(chk_hit[0]), 32'd1);
        check("c3_fwd0", chk_data[0], fwd_fc);
        check("c3_hit1", 32'(chk_hit[1]), 32'd1);
        push(2'b11, 32'h40, 32'h7, 32'h44, 32'h8);
        drain_en = 1'b1;
        #1;
        check("c3_ready", 32'(req_ready), 32'd1);
        tick();
        expect_write("c3_pop", 32'h30, 32'h5);
        check("c3_after_ready", 32'(req_ready), 32'd1);
        req_valid = 2'b00;
        drain_en = 1'b0;
        chk_addr[1] = 32'h44;
        #1;
        check("c3_lane1_absent", 32'(chk_hit[1]), 32'd0);
        tick();
        check("c3_idle_we", 32'(we), 32'd0);

        // reset with 3 stores pending discards them
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_we", 32'(we), 32'd0);
        check("mid_rst_wa", wa, 32'h0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        drain_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_we", 32'(we), 32'd0);
        end
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
